// File: rtl/linebuf_seq_pkg.sv
// Shared types and defaults for the line-buffer run-time sequencer.
package linebuf_seq_pkg;

    localparam int LB_DEPTH_W    = 16;
    localparam int LB_ITER_W     = 32;
    localparam int FLUSH_CYC_DEF = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLUSH  = 3'd1,
        FILL   = 3'd2,
        STREAM = 3'd3,
        WAIT   = 3'd4,
        DONE   = 3'd5
    } lb_state_t;

    typedef struct packed {
        logic [LB_DEPTH_W-1:0] depth;
        logic [LB_ITER_W-1:0]  iter_cnt;
    } lb_cfg_t;

endpackage

// File: rtl/linebuf_seq_ctrl_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module lb_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // count register, holds at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= {W{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {W{1'b0}};
        end else if (i_en && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/linebuf_seq_ctrl.sv
// Line-buffer sequencer: flush, fill to depth, stream write+read, count returns, done.
// Optional performance counters when LB_SEQ_PERF_EN is defined.
module linebuf_seq_ctrl
    import linebuf_seq_pkg::*;
#(
    parameter int DEPTH_W   = LB_DEPTH_W,
    parameter int ITER_W    = LB_ITER_W,
    parameter int FLUSH_CYC = FLUSH_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DEPTH_W-1:0] cfg_depth,
    input  logic [ITER_W-1:0] cfg_iter_cnt,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              mem_flush,
    output logic              mem_wen,
    output logic              mem_ren,
    input  logic              mem_valid_out,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
`ifdef LB_SEQ_PERF_EN
    ,
    output logic [ITER_W-1:0] stall_cyc,
    output logic [ITER_W-1:0] job_cyc
`endif
);

    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FW-1:0]      FLUSH_LAST = FW'(FLUSH_CYC - 1);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = {{(DEPTH_W-1){1'b0}}, 1'b1};
    localparam logic [ITER_W-1:0]  ITER_ONE   = {{(ITER_W-1){1'b0}}, 1'b1};

    lb_state_t          r_state;
    lb_state_t          w_next;
    logic [DEPTH_W-1:0] r_depth;
    logic [ITER_W-1:0]  r_iter;
    logic               r_cfg_err;
    logic [FW-1:0]      w_flush_cnt;
    logic [DEPTH_W-1:0] w_fill_cnt;
    logic [ITER_W-1:0]  w_rd_cnt;
    logic [ITER_W-1:0]  w_vo_cnt;
    logic               w_accept;
    logic               w_vo_inc;
    logic               w_vo_hit;

    assign w_accept = cfg_valid & clk_en & (r_state == IDLE);
    // returns are only meaningful once reads can have been issued
    assign w_vo_inc = clk_en & mem_valid_out & ((r_state == STREAM) | (r_state == WAIT));
    assign w_vo_hit = (w_vo_cnt == r_iter) | (w_vo_inc & (w_vo_cnt == (r_iter - ITER_ONE)));

    // output decode from the registered state
    always_comb begin
        cfg_ready = (r_state == IDLE);
        busy      = (r_state != IDLE);
        mem_flush = (r_state == FLUSH);
        done      = (r_state == DONE);
        cfg_err   = r_cfg_err;
        case (r_state)
            FILL:    in_ready = clk_en;
            STREAM:  in_ready = clk_en & out_ready & (w_rd_cnt < r_iter);
            default: in_ready = 1'b0;
        endcase
        mem_wen = in_valid & in_ready;
        mem_ren = mem_wen & (r_state == STREAM);
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (cfg_iter_cnt == {ITER_W{1'b0}}) w_next = DONE;
                    else                                w_next = FLUSH;
                end else begin
                    w_next = IDLE;
                end
            end
            FLUSH: begin
                if (clk_en && (w_flush_cnt == FLUSH_LAST)) w_next = FILL;
                else                                       w_next = FLUSH;
            end
            FILL: begin
                if (mem_wen && (w_fill_cnt == (r_depth - DEPTH_ONE))) w_next = STREAM;
                else                                                  w_next = FILL;
            end
            STREAM: begin
                if (mem_ren && (w_rd_cnt == (r_iter - ITER_ONE))) w_next = WAIT;
                else                                              w_next = STREAM;
            end
            WAIT: begin
                if (clk_en && w_vo_hit) w_next = DONE;
                else                    w_next = WAIT;
            end
            DONE: begin
                if (clk_en) w_next = IDLE;
                else        w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // job config and sticky error; a zero depth still needs one word of line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_depth   <= {DEPTH_W{1'b0}};
            r_iter    <= {ITER_W{1'b0}};
            r_cfg_err <= 1'b0;
        end else if (w_accept) begin
            r_depth   <= (cfg_depth == {DEPTH_W{1'b0}}) ? DEPTH_ONE : cfg_depth;
            r_iter    <= cfg_iter_cnt;
            r_cfg_err <= (cfg_depth == {DEPTH_W{1'b0}}) | (cfg_iter_cnt == {ITER_W{1'b0}});
        end else begin
            r_depth   <= r_depth;
            r_iter    <= r_iter;
            r_cfg_err <= r_cfg_err;
        end
    end

    lb_sat_counter #(.W(FW)) u_flush_cnt (
        .clk(clk), .reset(reset), .i_clr(w_accept),
        .i_en(clk_en & (r_state == FLUSH)), .o_cnt(w_flush_cnt)
    );

    lb_sat_counter #(.W(DEPTH_W)) u_fill_cnt (
        .clk(clk), .reset(reset), .i_clr(w_accept),
        .i_en(mem_wen & (r_state == FILL)), .o_cnt(w_fill_cnt)
    );

    lb_sat_counter #(.W(ITER_W)) u_rd_cnt (
        .clk(clk), .reset(reset), .i_clr(w_accept),
        .i_en(mem_ren), .o_cnt(w_rd_cnt)
    );

    lb_sat_counter #(.W(ITER_W)) u_vo_cnt (
        .clk(clk), .reset(reset), .i_clr(w_accept),
        .i_en(w_vo_inc), .o_cnt(w_vo_cnt)
    );

`ifdef LB_SEQ_PERF_EN
    lb_sat_counter #(.W(ITER_W)) u_stall_cnt (
        .clk(clk), .reset(reset), .i_clr(w_accept),
        .i_en(clk_en & in_valid & ~in_ready & ((r_state == FILL) | (r_state == STREAM))),
        .o_cnt(stall_cyc)
    );

    lb_sat_counter #(.W(ITER_W)) u_job_cnt (
        .clk(clk), .reset(reset), .i_clr(w_accept),
        .i_en(clk_en & (r_state != IDLE)), .o_cnt(job_cyc)
    );
`else
`endif

endmodule

// File: tb/tb_linebuf_seq_ctrl.sv
// Directed bench for linebuf_seq_ctrl with a one-cycle-latency memory core model.
module tb_linebuf_seq_ctrl;
    import linebuf_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset, clk_en, cfg_valid, cfg_ready;
    logic [15:0] cfg_depth;
    logic [31:0] cfg_iter_cnt;
    logic        in_valid, in_ready, out_ready;
    logic        mem_flush, mem_wen, mem_ren, mem_valid_out;
    logic        busy, done, cfg_err;
`ifdef LB_SEQ_PERF_EN
    logic [31:0] stall_cyc, job_cyc;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0, accept_cyc = 0, done_cyc = 0, last_vo_cyc = 0;
    int n_flush = 0, n_wo = 0, n_wr = 0, n_vo = 0, n_done = 0, n_bad = 0;
    int b_flush, b_wo, b_wr, b_vo, b_done;

    always #5 clk = ~clk;

    linebuf_seq_ctrl dut (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_depth(cfg_depth), .cfg_iter_cnt(cfg_iter_cnt),
        .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
        .mem_flush(mem_flush), .mem_wen(mem_wen), .mem_ren(mem_ren),
        .mem_valid_out(mem_valid_out),
        .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef LB_SEQ_PERF_EN
        , .stall_cyc(stall_cyc), .job_cyc(job_cyc)
`endif
    );

    // memory core stand-in: read data valid one cycle after ren
    always @(posedge clk or negedge reset) begin
        if (!reset)      mem_valid_out <= 1'b0;
        else if (clk_en) mem_valid_out <= mem_ren;
    end

    // event monitor sampled at the active edge
    always @(posedge clk) begin
        if (reset) begin
            cyc <= cyc + 1;
            if (cfg_valid & cfg_ready & clk_en) accept_cyc <= cyc;
            if (clk_en & mem_flush) n_flush <= n_flush + 1;
            if (mem_wen & !mem_ren) n_wo <= n_wo + 1;
            if (mem_ren) n_wr <= n_wr + 1;
            if ((mem_ren & !out_ready) | (mem_ren & !mem_wen)) n_bad <= n_bad + 1;
            if (clk_en & mem_valid_out) begin
                n_vo        <= n_vo + 1;
                last_vo_cyc <= cyc;
            end
            if (clk_en & done) begin
                n_done   <= n_done + 1;
                done_cyc <= cyc;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        b_flush = n_flush; b_wo = n_wo; b_wr = n_wr; b_vo = n_vo; b_done = n_done;
    endtask

    task automatic start_job(input lb_cfg_t c);
        int k;
        k = 0;
        while (!cfg_ready && k < 50) begin
            tick(1);
            k++;
        end
        if (!cfg_ready) check_eq("idle_timeout", 64'd0, 64'd1);
        snap();
        cfg_depth    = c.depth;
        cfg_iter_cnt = c.iter_cnt;
        cfg_valid    = 1'b1;
        tick(1);
        cfg_valid    = 1'b0;
    endtask

    task automatic wait_done(input bit toggle);
        int k;
        int d0;
        k  = 0;
        d0 = n_done;
        while (n_done == d0 && k < 400) begin
            if (toggle) out_ready = (k % 2 == 0);
            tick(1);
            k++;
        end
        if (n_done == d0) check_eq("done_timeout", 64'd0, 64'd1);
        out_ready = 1'b1;
    endtask

    initial begin
        lb_cfg_t c;
        int k;
        int w;
        reset = 1'b0; clk_en = 1'b1; cfg_valid = 1'b0; cfg_depth = 16'd0;
        cfg_iter_cnt = 32'd0; in_valid = 1'b0; out_ready = 1'b1;
        tick(2);
        check_eq("rst_cfg_ready", cfg_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_cfg_err", cfg_err, 0);
        check_eq("rst_flush", mem_flush, 0);
        check_eq("rst_in_ready", in_ready, 0);
        reset = 1'b1;
        in_valid = 1'b1;
        tick(1);

        // depth 4, iter 8, continuous flow
        c = '{depth: 16'd4, iter_cnt: 32'd8};
        start_job(c);
        check_eq("t1_busy_holdoff", cfg_ready, 0);
        wait_done(1'b0);
        tick(2);
        check_eq("t1_flush", n_flush - b_flush, 2);
        check_eq("t1_wen_only", n_wo - b_wo, 4);
        check_eq("t1_wen_ren", n_wr - b_wr, 8);
        check_eq("t1_vo", n_vo - b_vo, 8);
        check_eq("t1_done_once", n_done - b_done, 1);
        check_eq("t1_done_lat", done_cyc - last_vo_cyc, 1);
        check_eq("t1_cfg_err", cfg_err, 0);
        check_eq("t1_idle", cfg_ready, 1);

        // depth 0 behaves as depth 1
        c = '{depth: 16'd0, iter_cnt: 32'd3};
        start_job(c);
        check_eq("t2_cfg_err", cfg_err, 1);
        wait_done(1'b0);
        check_eq("t2_flush", n_flush - b_flush, 2);
        check_eq("t2_wen_only", n_wo - b_wo, 1);
        check_eq("t2_wen_ren", n_wr - b_wr, 3);

        // iter 0 goes straight to done
        c = '{depth: 16'd5, iter_cnt: 32'd0};
        start_job(c);
        check_eq("t3_done_now", done, 1);
        wait_done(1'b0);
        tick(2);
        check_eq("t3_flush", n_flush - b_flush, 0);
        check_eq("t3_wen", (n_wo - b_wo) + (n_wr - b_wr), 0);
        check_eq("t3_done_lat", done_cyc - accept_cyc, 1);
        check_eq("t3_done_once", n_done - b_done, 1);
        check_eq("t3_cfg_err", cfg_err, 1);

        // out_ready toggling during stream
        c = '{depth: 16'd2, iter_cnt: 32'd6};
        start_job(c);
        check_eq("t4_err_clear", cfg_err, 0);
        wait_done(1'b1);
        check_eq("t4_wen_ren", n_wr - b_wr, 6);
        check_eq("t4_wen_only", n_wo - b_wo, 2);
        check_eq("t4_vo", n_vo - b_vo, 6);
        check_eq("t4_no_bad_ren", n_bad, 0);

        // reset mid-stream
        c = '{depth: 16'd2, iter_cnt: 32'd10};
        start_job(c);
        k = 0;
        while ((n_wr - b_wr) < 3 && k < 100) begin
            tick(1);
            k++;
        end
        check_eq("t5_in_stream", mem_ren, 1);
        #2 reset = 1'b0;
        #1;
        check_eq("t5_rst_in_ready", in_ready, 0);
        check_eq("t5_rst_wen", mem_wen, 0);
        check_eq("t5_rst_ren", mem_ren, 0);
        check_eq("t5_rst_busy", busy, 0);
        check_eq("t5_rst_cfg_ready", cfg_ready, 1);
        tick(2);
        reset = 1'b1;
        tick(1);
        check_eq("t5_no_done", n_done - b_done, 0);
        c = '{depth: 16'd3, iter_cnt: 32'd4};
        start_job(c);
        wait_done(1'b0);
        check_eq("t5b_wen_only", n_wo - b_wo, 3);
        check_eq("t5b_wen_ren", n_wr - b_wr, 4);
        check_eq("t5b_vo", n_vo - b_vo, 4);

        // clk_en low for 5 cycles mid-fill
        c = '{depth: 16'd6, iter_cnt: 32'd4};
        start_job(c);
        k = 0;
        while ((n_wo - b_wo) < 2 && k < 100) begin
            tick(1);
            k++;
        end
        clk_en = 1'b0;
        w = n_wo;
        tick(5);
        check_eq("t6_frz_wen", n_wo - w, 0);
        check_eq("t6_frz_busy", busy, 1);
        check_eq("t6_frz_in_ready", in_ready, 0);
        check_eq("t6_frz_flush", mem_flush, 0);
        clk_en = 1'b1;
        wait_done(1'b0);
        check_eq("t6_wen_only", n_wo - b_wo, 6);
        check_eq("t6_wen_ren", n_wr - b_wr, 4);
        check_eq("t6_done", n_done - b_done, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
